// File: rtl/cla_pkg.sv
// Shared constants, result type and 4-bit carry-lookahead group helpers
// used by the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int CLA_GROUP_W = 4;

  typedef struct packed {
    logic [CLA_GROUP_W-1:0] sum;
    logic                   cout;
    logic                   ovf;
  } cla_res_t;

  function automatic int cla_stages(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  // Sum-only group, for groups whose carry-out is produced by the segment lookahead.
  function automatic logic [CLA_GROUP_W-1:0] cla_group_sum(
    input logic [CLA_GROUP_W-1:0] a,
    input logic [CLA_GROUP_W-1:0] b,
    input logic                   cin
  );
    logic [3:0] p;
    logic [2:0] g;
    logic [3:1] c;
    p    = a ^ b;
    g    = a[2:0] & b[2:0];
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    return p ^ {c[3:1], cin};
  endfunction

  function automatic cla_res_t cla_group(
    input logic [CLA_GROUP_W-1:0] a,
    input logic [CLA_GROUP_W-1:0] b,
    input logic                   cin
  );
    logic [3:0] p;
    logic [3:0] g;
    logic [4:1] c;
    cla_res_t   r;
    p    = a ^ b;
    g    = a & b;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    r.sum  = p ^ {c[3:1], cin};
    r.cout = c[4];
    r.ovf  = c[3] ^ c[4];
    return r;
  endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG_W-bit carry-lookahead segment built from 4-bit groups with a
// second-level group generate/propagate lookahead; c_msb is the carry into the top bit.
module cla_seg
  import cla_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic             cin,
  output logic [SEG_W-1:0] sum,
  output logic             cout,
  output logic             c_msb
);

  localparam int GROUPS = SEG_W / CLA_GROUP_W;

  logic [GROUPS-1:0] grp_g;
  logic [GROUPS-1:0] grp_p;
  logic [GROUPS:0]   grp_c;

  for (genvar i = 0; i < GROUPS; i++) begin : g_grp
    localparam int LO = i * CLA_GROUP_W;
    logic [CLA_GROUP_W-1:0] ga, gb, p, g;

    assign ga = a[LO +: CLA_GROUP_W];
    assign gb = b[LO +: CLA_GROUP_W];
    assign p  = ga ^ gb;
    assign g  = ga & gb;
    assign grp_p[i] = &p;
    assign grp_g[i] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);

    if (i < GROUPS - 1) begin : g_low
      assign sum[LO +: CLA_GROUP_W] = cla_group_sum(ga, gb, grp_c[i]);
    end else begin : g_top
      cla_res_t res;
      assign res = cla_group(ga, gb, grp_c[i]);
      assign sum[LO +: CLA_GROUP_W] = res.sum;
      // ovf = c3 ^ c4 inside the group, so the carry into the top bit is ovf ^ cout.
      assign c_msb = res.ovf ^ res.cout;
    end
  end

  // NOTE: every variable written here gets a value on every path first, so no latch is inferred.
  always_comb begin
    logic c;
    logic prop;
    grp_c    = '0;
    grp_c[0] = cin;
    c        = 1'b0;
    prop     = 1'b1;
    for (int i = 0; i < GROUPS; i++) begin
      c    = 1'b0;
      prop = 1'b1;
      for (int j = i; j >= 0; j--) begin
        c    = c | (prop & grp_g[j]);
        prop = prop & grp_p[j];
      end
      grp_c[i+1] = c | (prop & cin);
    end
  end

  assign cout = grp_c[GROUPS];

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder, one SEG_W-bit segment per stage with registered carries.
// Define CLA_ADDSUB_EN to add the in_sub port and turn the block into an adder/subtractor.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
`ifdef CLA_ADDSUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int STAGES = cla_stages(WIDTH, SEG_W);

  if ((WIDTH % SEG_W) != 0 || (SEG_W % CLA_GROUP_W) != 0) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH=%0d must be a multiple of SEG_W=%0d, which must be a multiple of %0d",
           WIDTH, SEG_W, CLA_GROUP_W);
  end

  logic             adv;
  logic [WIDTH-1:0] eff_b;
  logic             eff_cin;

`ifdef CLA_ADDSUB_EN
  // Inverting b here lets the subtract select ride along with the skewed operand bits.
  assign eff_b   = in_b ^ {WIDTH{in_sub}};
  assign eff_cin = in_cin ^ in_sub;
`else
  assign eff_b   = in_b;
  assign eff_cin = in_cin;
`endif

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * SEG_W;
    localparam int HI = LO + SEG_W - 1;

    logic [WIDTH-1:LO] op_a, op_b;
    logic              prev_valid;
    logic              seg_cin, seg_cout, seg_c_msb;
    logic [SEG_W-1:0]  seg_sum;
    logic [HI:0]       sum_d, sum_q;
    logic              valid_q, carry_q;

    if (k == 0) begin : g_head
      assign op_a       = in_a;
      assign op_b       = eff_b;
      assign seg_cin    = eff_cin;
      assign prev_valid = in_valid;
      assign sum_d      = seg_sum;
    end else begin : g_body
      assign op_a       = g_stage[k-1].g_skew.a_q;
      assign op_b       = g_stage[k-1].g_skew.b_q;
      assign seg_cin    = g_stage[k-1].carry_q;
      assign prev_valid = g_stage[k-1].valid_q;
      assign sum_d      = {seg_sum, g_stage[k-1].sum_q};
    end

    cla_seg #(.SEG_W(SEG_W)) u_seg (
      .a     (op_a[HI:LO]),
      .b     (op_b[HI:LO]),
      .cin   (seg_cin),
      .sum   (seg_sum),
      .cout  (seg_cout),
      .c_msb (seg_c_msb)
    );

    // NOTE: sequential state uses non-blocking assignments so every stage samples the
    // previous stage's pre-edge value; datapath registers are reset too so out_sum reads 0.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        carry_q <= 1'b0;
        sum_q   <= '0;
      end else if (adv) begin
        valid_q <= prev_valid;
        if (prev_valid) begin
          carry_q <= seg_cout;
          sum_q   <= sum_d;
        end
      end
    end

    if (k < STAGES - 1) begin : g_skew
      logic [WIDTH-1:HI+1] a_q, b_q;
      logic                unused_c_msb;

      assign unused_c_msb = seg_c_msb;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv && prev_valid) begin
          a_q <= op_a[WIDTH-1:HI+1];
          b_q <= op_b[WIDTH-1:HI+1];
        end
      end
    end else begin : g_tail
      logic ovf_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (adv && prev_valid) begin
          ovf_q <= seg_c_msb ^ seg_cout;
        end
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].valid_q;
  assign out_sum   = g_stage[STAGES-1].sum_q;
  assign out_cout  = g_stage[STAGES-1].carry_q;
  assign out_ovf   = g_stage[STAGES-1].g_tail.ovf_q;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder at WIDTH=16, SEG_W=4 (four stages).
module tb_pipelined_cla_adder;

  localparam int WIDTH = 16;
  localparam int SEG_W = 4;

  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready, in_cin, in_sub;
  logic [WIDTH-1:0] in_a, in_b;
  logic             out_valid, out_ready, out_cout, out_ovf;
  logic [WIDTH-1:0] out_sum;

  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  bit   took;
  res_t exp_q[$];
  res_t got_q[$];
  int   deliv_cyc[$];

  always #5 clk = ~clk;

  pipelined_cla_adder #(.WIDTH(WIDTH), .SEG_W(SEG_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
`ifdef CLA_ADDSUB_EN
    .in_sub    (in_sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic cin, input logic sub);
    logic [WIDTH-1:0] bb;
    logic [WIDTH:0]   full;
    res_t             r;
    bb     = sub ? ~b : b;
    full   = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin ^ sub};
    r.sum  = full[WIDTH-1:0];
    r.cout = full[WIDTH];
    r.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (r.sum[WIDTH-1] != a[WIDTH-1]);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: handshakes are observed at the falling edge, inputs change just after the rising edge.
  task automatic tick();
    res_t e;
    @(negedge clk);
    took = in_valid && in_ready;
    if (out_valid && out_ready) begin
      check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
      got_q.push_back(res_t'{out_sum, out_cout, out_ovf});
      deliv_cyc.push_back(cycle);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("out_sum", 32'(out_sum), 32'(e.sum));
        check("out_cout", 32'(out_cout), 32'(e.cout));
        check("out_ovf", 32'(out_ovf), 32'(e.ovf));
      end
    end
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic cin, input logic sub);
    int n;
    in_a     = a;
    in_b     = b;
    in_cin   = cin;
    in_sub   = sub;
    in_valid = 1'b1;
    exp_q.push_back(model(a, b, cin, sub));
    n = 0;
    do begin
      tick();
      n++;
    end while (!took && n < 50);
    check("send_accepted", 32'(took), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int stale;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_sub    = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    tick();
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();

    // 1: FFFF + 0001, latency of four cycles
    got_q.delete();
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t1_not_yet_valid", 32'(out_valid), 32'd0);
      tick();
    end
    check("t1_valid", 32'(out_valid), 32'd1);
    check("t1_sum", 32'(out_sum), 32'h0000);
    check("t1_cout", 32'(out_cout), 32'd1);
    check("t1_ovf", 32'(out_ovf), 32'd0);
    drain();
    tick();
    check("t1_valid_clears", 32'(out_valid), 32'd0);

    // 2: signed overflow cases
    got_q.delete();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    send(16'h8000, 16'h8000, 1'b0, 1'b0);
    drain();
    check("t2_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("t2a_sum", 32'(got_q[0].sum), 32'h8000);
      check("t2a_cout", 32'(got_q[0].cout), 32'd0);
      check("t2a_ovf", 32'(got_q[0].ovf), 32'd1);
      check("t2b_sum", 32'(got_q[1].sum), 32'h0000);
      check("t2b_cout", 32'(got_q[1].cout), 32'd1);
      check("t2b_ovf", 32'(got_q[1].ovf), 32'd1);
    end

    // 3: eight back-to-back random beats, results on consecutive cycles
    got_q.delete();
    deliv_cyc.delete();
    for (int i = 0; i < 8; i++)
      send(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b0);
    drain();
    check("t3_count", 32'(deliv_cyc.size()), 32'd8);
    if (deliv_cyc.size() == 8)
      check("t3_consecutive", 32'(deliv_cyc[7] - deliv_cyc[0]), 32'd7);

    // 4: fill the pipeline with the consumer stalled, hold three cycles, then release
    got_q.delete();
    out_ready = 1'b0;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'hF000, 16'h1000, 1'b0, 1'b0);
    send(16'h00FF, 16'h0001, 1'b1, 1'b0);
    send(16'hABCD, 16'h5432, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check("t4_in_ready_low", 32'(in_ready), 32'd0);
      check("t4_valid_held", 32'(out_valid), 32'd1);
      check("t4_sum_held", 32'(out_sum), 32'h3333);
      check("t4_cout_held", 32'(out_cout), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    drain();
    check("t4_count", 32'(got_q.size()), 32'd4);
    if (got_q.size() == 4) begin
      check("t4_b0_sum", 32'(got_q[0].sum), 32'h3333);
      check("t4_b1_sum", 32'(got_q[1].sum), 32'h0000);
      check("t4_b1_cout", 32'(got_q[1].cout), 32'd1);
      check("t4_b2_sum", 32'(got_q[2].sum), 32'h0101);
      check("t4_b3_sum", 32'(got_q[3].sum), 32'h0000);
      check("t4_b3_cout", 32'(got_q[3].cout), 32'd1);
    end

    // 5: asynchronous reset with three beats in flight
    send(16'h0001, 16'h0002, 1'b0, 1'b0);
    send(16'h0003, 16'h0004, 1'b0, 1'b0);
    send(16'h0005, 16'h0006, 1'b0, 1'b0);
    tick();
    check("t5_pre_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_async_valid", 32'(out_valid), 32'd0);
    check("t5_async_sum", 32'(out_sum), 32'd0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    got_q.delete();
    stale = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) stale++;
    end
    check("t5_no_stale", 32'(stale), 32'd0);
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    drain();
    check("t5_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() == 1)
      check("t5_sum", 32'(got_q[0].sum), 32'h2345);

`ifdef CLA_ADDSUB_EN
    // 6: subtraction
    got_q.delete();
    send(16'h0005, 16'h0007, 1'b0, 1'b1);
    send(16'h0007, 16'h0005, 1'b0, 1'b1);
    drain();
    check("t6_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("t6a_sum", 32'(got_q[0].sum), 32'hFFFE);
      check("t6a_cout", 32'(got_q[0].cout), 32'd0);
      check("t6b_sum", 32'(got_q[1].sum), 32'h0002);
      check("t6b_cout", 32'(got_q[1].cout), 32'd1);
    end
`endif

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
